mem_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arbiter_if.sv | 50 +++++
 rtl/mem_arbiter.sv | 97 +++++++++
 tb/tb_mem_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arbiter shared types and constants.
// Arbiter states, default widths and burst counter width.
package mem_arb_pkg;

  localparam int AW_DEF      = 16;
  localparam int DW_DEF      = 8;
  localparam int BURST_CNT_W = 4;

  typedef enum logic [2:0] {
    ST_CPU,
    ST_LD_MAR,
    ST_LD_WR,
    ST_LD_RD,
    ST_LD_ACK,
    ST_RESTORE
  } state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter bus bundle: CPU side, loader side, memory side.
// slave = arbiter view, master = environment view.
interface mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 8
);

  logic          cpu_mar_we;
  logic          cpu_ram_we;
  logic          cpu_oe;
  logic [AW-1:0] cpu_bus;
  logic          cpu_boundary;
  logic          cpu_stall;

  logic          ld_req;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          ld_ack;
  logic [DW-1:0] ld_rdata;

  logic          mem_mar_we;
  logic          mem_ram_we;
  logic          mem_oe;
  logic [AW-1:0] mem_bus;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_mar_we, cpu_ram_we, cpu_oe,
    input  cpu_bus, cpu_boundary,
    output cpu_stall,
    input  ld_req, ld_we, ld_addr, ld_data,
    output ld_ack, ld_rdata,
    output mem_mar_we, mem_ram_we, mem_oe,
    output mem_bus,
    input  mem_rdata
  );

  modport master (
    output cpu_mar_we, cpu_ram_we, cpu_oe,
    output cpu_bus, cpu_boundary,
    input  cpu_stall,
    output ld_req, ld_we, ld_addr, ld_data,
    input  ld_ack, ld_rdata,
    input  mem_mar_we, mem_ram_we, mem_oe,
    input  mem_bus,
    output mem_rdata
  );

endinterface

// File: rtl/mem_arbiter.sv
// Shares MAR/RAM between CPU and loader port.
// Grants only at instruction boundaries, restores CPU MAR after.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int BURST_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  localparam logic [BURST_CNT_W-1:0] BMAX =
    BURST_CNT_W'(BURST_MAX);

  state_e                 state_q, state_d;
  logic [AW-1:0]          shadow_q, shadow_d;
  logic [BURST_CNT_W-1:0] burst_q, burst_d;
  logic [DW-1:0]          rdata_q, rdata_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_CPU;
      shadow_q <= '0;
      burst_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      burst_q  <= burst_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.ld_rdata = rdata_q;

  always_comb begin
    state_d        = state_q;
    shadow_d       = shadow_q;
    burst_d        = burst_q;
    rdata_d        = rdata_q;
    bus.cpu_stall  = 1'b1;
    bus.ld_ack     = 1'b0;
    bus.mem_mar_we = 1'b0;
    bus.mem_ram_we = 1'b0;
    bus.mem_oe     = 1'b0;
    bus.mem_bus    = '0;
    unique case (state_q)
      ST_CPU: begin
        bus.cpu_stall  = 1'b0;
        bus.mem_mar_we = bus.cpu_mar_we;
        bus.mem_ram_we = bus.cpu_ram_we;
        bus.mem_oe     = bus.cpu_oe;
        bus.mem_bus    = bus.cpu_bus;
        if (bus.cpu_mar_we)
          shadow_d = bus.cpu_bus;
        if (bus.ld_req && bus.cpu_boundary)
          state_d = ST_LD_MAR;
      end
      ST_LD_MAR: begin
        bus.mem_bus    = bus.ld_addr;
        bus.mem_mar_we = 1'b1;
        state_d = bus.ld_we ? ST_LD_WR : ST_LD_RD;
      end
      ST_LD_WR: begin
        bus.mem_bus    = AW'(bus.ld_data);
        bus.mem_ram_we = 1'b1;
        state_d        = ST_LD_ACK;
      end
      ST_LD_RD: begin
        bus.mem_oe = 1'b1;
        rdata_d    = bus.mem_rdata;
        state_d    = ST_LD_ACK;
      end
      ST_LD_ACK: begin
        bus.ld_ack = 1'b1;
        burst_d    = burst_q + 1'b1;
        state_d    = ST_RESTORE;
      end
      ST_RESTORE: begin
        bus.mem_bus    = shadow_q;
        bus.mem_mar_we = 1'b1;
        // limit is checked before the ACK increment can exceed it
        if (bus.ld_req && (burst_q < BMAX)) begin
          state_d = ST_LD_MAR;
        end else begin
          state_d = ST_CPU;
          burst_d = '0;
        end
      end
      default: state_d = ST_CPU;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter.
// Memory model, loader scoreboard, protocol monitor.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  typedef struct packed {
    logic        we;
    logic [15:0] a;
    logic [7:0]  d;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   acks_total = 0;

  mem_arbiter_if #(.AW(16), .DW(8)) ifc();

  mem_arbiter #(
    .AW(16), .DW(8), .BURST_MAX(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  always #5 clk = ~clk;

  logic [7:0]  ram [256] = '{default: 8'h00};
  logic [7:0]  ref_mem [256] = '{default: 8'h00};
  logic [15:0] mar = '0;
  logic [15:0] cpu_mar = '0;
  txn_t        pend_q[$];
  txn_t        exp_q[$];

  assign ifc.mem_rdata = ram[mar[7:0]];

  always @(posedge clk) begin
    if (ifc.mem_mar_we) mar <= ifc.mem_bus;
    if (ifc.mem_ram_we) ram[mar[7:0]] <= ifc.mem_bus[7:0];
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // loader request fields must hold from req until ack
  txn_t hold_t;
  logic pend_v = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pend_v <= 1'b0;
    end else begin
      if (ifc.ld_req && pend_v)
        chk("proto_stable",
            {ifc.ld_we, ifc.ld_addr, ifc.ld_data}, hold_t);
      if (ifc.ld_ack) begin
        pend_v <= 1'b0;
      end else if (ifc.ld_req && !pend_v) begin
        hold_t <= {ifc.ld_we, ifc.ld_addr, ifc.ld_data};
        pend_v <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin : cons
    txn_t t;
    if (rst_n && ifc.ld_ack) begin
      acks_total <= acks_total + 1;
      if (exp_q.size() == 0) begin
        chk("ack_expected", 0, 1);
      end else begin
        t = exp_q.pop_front();
        chk("ack_mar", mar, t.a);
        if (t.we) chk("wr_ram", ram[t.a[7:0]], t.d);
        else      chk("rd_data", ifc.ld_rdata, t.d);
      end
    end
  end

  task automatic present();
    txn_t t;
    if (pend_q.size() == 0) begin
      ifc.ld_req = 1'b0;
    end else begin
      t = pend_q.pop_front();
      if (t.we) ref_mem[t.a[7:0]] = t.d;
      else      t.d = ref_mem[t.a[7:0]];
      ifc.ld_req  = 1'b1;
      ifc.ld_we   = t.we;
      ifc.ld_addr = t.a;
      ifc.ld_data = t.we ? t.d : 8'h00;
      exp_q.push_back(t);
    end
  endtask

  task automatic run_grant(output int n, output int acks);
    logic [15:0] ga;
    logic        got;
    ga = ifc.ld_addr;
    ifc.cpu_boundary = 1'b1;
    cyc();
    ifc.cpu_boundary = 1'b0;
    chk("grant_stall", ifc.cpu_stall, 1);
    chk("grant_mar_we", ifc.mem_mar_we, 1);
    chk("grant_bus", ifc.mem_bus, ga);
    n = 0;
    acks = 0;
    while (ifc.cpu_stall && n < 64) begin
      n++;
      got = ifc.ld_ack;
      if (got) acks++;
      cyc();
      if (got) present();
    end
    chk("stall_released", ifc.cpu_stall, 0);
    chk("mar_restored", mar, cpu_mar);
  endtask

  initial begin
    int   n, a, ak;
    logic sticky;
    rst_n = 1'b0;
    ifc.cpu_mar_we   = 1'b0;
    ifc.cpu_ram_we   = 1'b0;
    ifc.cpu_oe       = 1'b0;
    ifc.cpu_bus      = 16'h00C3;
    ifc.cpu_boundary = 1'b0;
    ifc.ld_req  = 1'b0;
    ifc.ld_we   = 1'b0;
    ifc.ld_addr = '0;
    ifc.ld_data = '0;
    #12;
    chk("rst_stall", ifc.cpu_stall, 0);
    chk("rst_ack", ifc.ld_ack, 0);
    chk("rst_rdata", ifc.ld_rdata, 0);
    chk("rst_mar_we", ifc.mem_mar_we, 0);
    chk("rst_ram_we", ifc.mem_ram_we, 0);
    chk("rst_oe", ifc.mem_oe, 0);
    chk("rst_bus", ifc.mem_bus, 16'h00C3);
    rst_n = 1'b1;
    cyc();

    ifc.cpu_mar_we = 1'b1;
    ifc.cpu_bus    = 16'h0012;
    #1;
    chk("pt_mar_we", ifc.mem_mar_we, 1);
    chk("pt_bus_mar", ifc.mem_bus, 16'h0012);
    chk("pt_stall", ifc.cpu_stall, 0);
    cyc();
    chk("pt_mar", mar, 16'h0012);
    ifc.cpu_mar_we = 1'b0;
    ifc.cpu_ram_we = 1'b1;
    ifc.cpu_bus    = 16'h00AB;
    #1;
    chk("pt_ram_we", ifc.mem_ram_we, 1);
    chk("pt_mar_we0", ifc.mem_mar_we, 0);
    chk("pt_bus_ram", ifc.mem_bus, 16'h00AB);
    cyc();
    ifc.cpu_ram_we = 1'b0;
    chk("pt_ram", ram[8'h12], 8'hAB);
    ref_mem[8'h12] = 8'hAB;
    ifc.cpu_oe = 1'b1;
    #1;
    chk("pt_oe", ifc.mem_oe, 1);
    ifc.cpu_oe = 1'b0;
    cpu_mar = 16'h0012;

    pend_q.push_back(txn_t'{we: 1'b1, a: 16'h0040, d: 8'h5A});
    present();
    ifc.cpu_boundary = 1'b1;
    #1;
    chk("wr_bnd_stall", ifc.cpu_stall, 0);
    cyc();
    ifc.cpu_boundary = 1'b0;
    chk("wr_mar_stall", ifc.cpu_stall, 1);
    chk("wr_mar_we", ifc.mem_mar_we, 1);
    chk("wr_mar_bus", ifc.mem_bus, 16'h0040);
    cyc();
    chk("wr_ram_we", ifc.mem_ram_we, 1);
    chk("wr_ram_mar0", ifc.mem_mar_we, 0);
    chk("wr_ram_bus", ifc.mem_bus, 16'h005A);
    cyc();
    chk("wr_ack", ifc.ld_ack, 1);
    chk("wr_ack_stall", ifc.cpu_stall, 1);
    chk("wr_ack_ram_we", ifc.mem_ram_we, 0);
    cyc();
    present();
    chk("wr_rst_mar_we", ifc.mem_mar_we, 1);
    chk("wr_rst_bus", ifc.mem_bus, 16'h0012);
    chk("wr_rst_ack", ifc.ld_ack, 0);
    cyc();
    chk("wr_done_stall", ifc.cpu_stall, 0);
    chk("wr_done_mar", mar, 16'h0012);

    pend_q.push_back(txn_t'{we: 1'b0, a: 16'h0040, d: 8'h00});
    present();
    run_grant(n, ak);
    chk("rd_cycles", n, 4);
    chk("rd_acks", ak, 1);
    chk("rd_hold", ifc.ld_rdata, 8'h5A);

    pend_q.push_back(txn_t'{we: 1'b1, a: 16'h0012, d: 8'h99});
    present();
    run_grant(n, ak);
    chk("cmar_cycles", n, 4);
    ifc.cpu_oe = 1'b1;
    #1;
    chk("cpu_sees_new", ifc.mem_rdata, 8'h99);
    ifc.cpu_oe = 1'b0;

    pend_q.push_back(txn_t'{we: 1'b1, a: 16'h0041, d: 8'h33});
    present();
    sticky = 1'b0;
    repeat (10) begin
      cyc();
      sticky = sticky | ifc.cpu_stall | ifc.ld_ack;
    end
    chk("gate_idle", sticky, 0);
    run_grant(n, ak);
    chk("gate_cycles", n, 4);
    chk("gate_acks", ak, 1);

    for (int i = 0; i < 6; i++)
      pend_q.push_back(txn_t'{we: 1'b1, a: 16'(i),
                              d: 8'(8'hC0 + i)});
    present();
    run_grant(n, ak);
    chk("burst1_cycles", n, 16);
    chk("burst1_acks", ak, 4);
    sticky = 1'b0;
    repeat (3) begin
      cyc();
      sticky = sticky | ifc.cpu_stall | ifc.ld_ack;
    end
    chk("burst_wait", sticky, 0);
    run_grant(n, ak);
    chk("burst2_cycles", n, 8);
    chk("burst2_acks", ak, 2);
    chk("rdata_kept", ifc.ld_rdata, 8'h5A);
    chk("sb_empty", exp_q.size(), 0);

    pend_q.push_back(txn_t'{we: 1'b1, a: 16'h0050, d: 8'h77});
    present();
    ifc.cpu_bus = 16'h1234;
    ifc.cpu_boundary = 1'b1;
    cyc();
    ifc.cpu_boundary = 1'b0;
    cyc();
    chk("rs_in_wr", ifc.mem_ram_we, 1);
    a = acks_total;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_stall", ifc.cpu_stall, 0);
    chk("rs_ack", ifc.ld_ack, 0);
    chk("rs_ram_we", ifc.mem_ram_we, 0);
    chk("rs_mar_we", ifc.mem_mar_we, 0);
    chk("rs_rdata", ifc.ld_rdata, 0);
    chk("rs_bus", ifc.mem_bus, 16'h1234);
    exp_q.delete();
    ifc.ld_req = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    chk("rs_no_ack", acks_total, a);
    chk("rs_no_write", ram[8'h50], 8'h00);
    cyc();
    ifc.cpu_mar_we = 1'b1;
    ifc.cpu_bus    = 16'h0022;
    #1;
    chk("post_mar_we", ifc.mem_mar_we, 1);
    chk("post_bus", ifc.mem_bus, 16'h0022);
    chk("post_stall", ifc.cpu_stall, 0);
    cyc();
    ifc.cpu_mar_we = 1'b0;
    chk("post_mar", mar, 16'h0022);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
